// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and helpers for the pending priority encoder.
package enc_pkg;

    localparam int ENC_MODE_FIXED = 0;
    localparam int ENC_MODE_RR    = 1;

    function automatic int enc_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pending_priority_encoder_if.sv
// Index-stream handshake between the encoder (master) and its consumer (slave).
interface pending_priority_encoder_if #(
    parameter int W = 3
) ();

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/pending_priority_encoder_prio_pick.sv
// Combinational circular lowest-index search over vec, beginning at position start.
module prio_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = enc_idx_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin : search
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start) + i) % N;
            if (!found && vec[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Captures request pulses into a pending vector and serialises them as an index stream
// over a valid/ready handshake, using fixed-priority or round-robin selection.
module pending_priority_encoder
    import enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = enc_idx_w(N),
    parameter int MODE = ENC_MODE_FIXED
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N-1:0]                req_i,
    input  logic                        clr_i,
    pending_priority_encoder_if.master  out_if,
    output logic [N-1:0]                pending_o,
    output logic                        overflow_o
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         overflow_q, overflow_d;

    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] pick_idx;
    logic         load;
    logic [N-1:0] pop_mask;

    // Round-robin resumes one past the last served index; fixed mode always scans from 0.
    always_comb begin
        start = '0;
        if (MODE == ENC_MODE_RR) begin
            start = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .vec   (pending_q),
        .start (start),
        .found (found),
        .idx   (pick_idx)
    );

    always_comb begin
        load     = !clr_i && (!out_valid_q || out_if.out_ready) && found;
        pop_mask = '0;
        if (load) begin
            pop_mask[pick_idx] = 1'b1;
        end

        pending_d   = (pending_q & ~pop_mask) | req_i;
        overflow_d  = |(req_i & pending_q & ~pop_mask);
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = pick_idx;
            ptr_d       = pick_idx;
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Flush overrides any concurrent load, handshake or incoming request.
        if (clr_i) begin
            pending_d   = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= LAST_IDX;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_idx   = out_idx_q;
    assign pending_o        = pending_q;
    assign overflow_o       = overflow_q;

endmodule
